// File: rtl/fifo_tx_pkg.sv
// Shared defaults and FSM state types for the store-and-forward TX FIFO.
// Imported by fifo_tx and frame_desc_fifo.
package eth_fifo_pkg;

    localparam int unsigned FIFO_TX_DEPTH      = 1024;
    localparam int unsigned FIFO_TX_MAX_FRAMES = 8;
    localparam logic [3:0]  KEEP_ALL           = 4'hF;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_DATA,
        DROP
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_BURST,
        RD_LAST
    } rd_state_t;

    // Only the frame's final beat carries a partial keep; every other beat is full.
    function automatic logic [3:0] beat_keep(input logic is_last, input logic [3:0] last_keep);
        return is_last ? last_keep : KEEP_ALL;
    endfunction

endpackage

// File: rtl/fifo_tx_if.sv
// 32-bit AXI-Stream bundle used for both the user-side input and the MAC-side output.
// master drives payload/valid, slave drives ready.
interface fifo_tx_if;

    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tkeep, input  tvalid, input  tlast, output tready);

endinterface

// File: rtl/fifo_tx_desc.sv
// Descriptor ring: one {end pointer, last tkeep} entry per committed frame.
// head is the oldest entry, count the number of committed frames not yet popped.
module frame_desc_fifo
    import eth_fifo_pkg::*;
#(
    parameter int unsigned DW    = 15,
    parameter int unsigned DEPTH = FIFO_TX_MAX_FRAMES
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [DW-1:0] r_ring [DEPTH];
    logic [AW:0]   r_wp;
    logic [AW:0]   r_rp;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_ring <= '{default: '0};
        end else begin
            if (push) begin
                r_ring[r_wp[AW-1:0]] <= push_data;
                r_wp                 <= r_wp + ONE;
            end
            if (pop) begin
                r_rp <= r_rp + ONE;
            end
        end
    end

    assign head  = r_ring[r_rp[AW-1:0]];
    assign count = r_wp - r_rp;

endmodule

// File: rtl/fifo_tx.sv
// Store-and-forward TX FIFO: whole frames are buffered before being streamed to the MAC.
// Optional macro FIFO_TX_STATS_EN adds tx_frame_cnt / drop_cnt statistics outputs.
module fifo_tx
    import eth_fifo_pkg::*;
#(
    parameter int unsigned DEPTH      = FIFO_TX_DEPTH,
    parameter int unsigned MAX_FRAMES = FIFO_TX_MAX_FRAMES
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    fifo_tx_if.slave                    s_axis,
    fifo_tx_if.master                   m_axis,
    output logic                        frame_drop,
    output logic [$clog2(MAX_FRAMES):0] frames_pending
`ifdef FIFO_TX_STATS_EN
    ,
    output logic [31:0]                 tx_frame_cnt,
    output logic [31:0]                 drop_cnt
`endif
);

    localparam int unsigned PW      = $clog2(DEPTH);
    localparam int unsigned FW      = $clog2(MAX_FRAMES);
    localparam int unsigned DW      = PW + 1 + 4;
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);
    localparam logic [PW:0] DEPTH_P = (PW+1)'(DEPTH);
    localparam logic [FW:0] MAX_P   = (FW+1)'(MAX_FRAMES);

    logic [31:0]   r_mem [DEPTH];
    logic [PW:0]   r_wr_ptr;
    logic [PW:0]   r_rd_ptr;
    logic [PW:0]   r_frame_start;
    logic [PW:0]   r_end_ptr;
    logic [3:0]    r_last_keep;
    wr_state_t     r_wr_state;
    rd_state_t     r_rd_state;
    logic          r_frame_drop;

    logic [31:0]   r_m_tdata;
    logic [3:0]    r_m_tkeep;
    logic          r_m_tvalid;
    logic          r_m_tlast;

    logic [PW:0]   w_used;
    logic [PW:0]   w_rd_ptr_nx;
    logic          w_s_ready;
    logic          w_s_hs;
    logic          w_wr_en;
    logic          w_fill;
    logic          w_push;
    logic          w_pop;
    logic          w_m_hs;
    logic          w_end0;
    logic          w_end1;
    logic [DW-1:0] w_push_data;
    logic [DW-1:0] w_head;
    logic [FW:0]   w_count;

    always_comb begin
        w_used      = r_wr_ptr - r_rd_ptr;
        w_rd_ptr_nx = r_rd_ptr + PTR_ONE;
        w_s_ready   = aresetn && (((w_used < DEPTH_P) && (w_count < MAX_P)) || (r_wr_state == DROP));
        w_s_hs      = s_axis.tvalid && w_s_ready;
        w_wr_en     = w_s_hs && (r_wr_state != DROP);
        // The accepted word would leave the buffer completely full without a tlast.
        w_fill      = (w_used == (DEPTH_P - PTR_ONE));
        w_push      = w_wr_en && s_axis.tlast;
        w_push_data = {r_wr_ptr + PTR_ONE, s_axis.tkeep};
        w_m_hs      = r_m_tvalid && m_axis.tready;
        w_pop       = w_m_hs && r_m_tlast;
        w_end0      = (w_rd_ptr_nx == r_end_ptr);
        w_end1      = ((w_rd_ptr_nx + PTR_ONE) == r_end_ptr);
    end

    frame_desc_fifo #(
        .DW    (DW),
        .DEPTH (MAX_FRAMES)
    ) u_desc (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count)
    );

    always_ff @(posedge aclk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[PW-1:0]] <= s_axis.tdata;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wr_state    <= WR_IDLE;
            r_wr_ptr      <= '0;
            r_frame_start <= '0;
            r_frame_drop  <= 1'b0;
        end else begin
            r_frame_drop <= 1'b0;
            if (w_s_hs) begin
                case (r_wr_state)
                    WR_IDLE: begin
                        r_frame_start <= r_wr_ptr;
                        if (s_axis.tlast) begin
                            r_wr_ptr <= r_wr_ptr + PTR_ONE;
                        end else if (w_fill) begin
                            r_wr_state <= DROP;
                        end else begin
                            r_wr_ptr   <= r_wr_ptr + PTR_ONE;
                            r_wr_state <= WR_DATA;
                        end
                    end
                    WR_DATA: begin
                        if (s_axis.tlast) begin
                            r_wr_ptr   <= r_wr_ptr + PTR_ONE;
                            r_wr_state <= WR_IDLE;
                        end else if (w_fill) begin
                            // Oversized frame: give back everything written for it.
                            r_wr_ptr   <= r_frame_start;
                            r_wr_state <= DROP;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + PTR_ONE;
                        end
                    end
                    DROP: begin
                        if (s_axis.tlast) begin
                            r_frame_drop <= 1'b1;
                            r_wr_state   <= WR_IDLE;
                        end
                    end
                    default: r_wr_state <= WR_IDLE;
                endcase
            end
        end
    end

    // The output register always holds the word at r_rd_ptr; the next word is
    // loaded on the handshake itself so tvalid never drops inside a frame.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_rd_state  <= RD_IDLE;
            r_rd_ptr    <= '0;
            r_end_ptr   <= '0;
            r_last_keep <= '0;
            r_m_tdata   <= '0;
            r_m_tkeep   <= '0;
            r_m_tvalid  <= 1'b0;
            r_m_tlast   <= 1'b0;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    if (w_count != '0) begin
                        r_end_ptr   <= w_head[DW-1:4];
                        r_last_keep <= w_head[3:0];
                        r_rd_state  <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (!r_m_tvalid) begin
                        r_m_tvalid <= 1'b1;
                        r_m_tdata  <= r_mem[r_rd_ptr[PW-1:0]];
                        r_m_tlast  <= w_end0;
                        r_m_tkeep  <= beat_keep(w_end0, r_last_keep);
                    end else if (w_m_hs) begin
                        r_rd_ptr <= w_rd_ptr_nx;
                        if (r_m_tlast) begin
                            r_m_tvalid <= 1'b0;
                            r_m_tlast  <= 1'b0;
                            r_rd_state <= RD_LAST;
                        end else begin
                            r_m_tdata <= r_mem[w_rd_ptr_nx[PW-1:0]];
                            r_m_tlast <= w_end1;
                            r_m_tkeep <= beat_keep(w_end1, r_last_keep);
                        end
                    end
                end
                RD_LAST: r_rd_state <= RD_IDLE;
                default: r_rd_state <= RD_IDLE;
            endcase
        end
    end

    assign s_axis.tready  = w_s_ready;
    assign m_axis.tdata   = r_m_tdata;
    assign m_axis.tkeep   = r_m_tkeep;
    assign m_axis.tvalid  = r_m_tvalid;
    assign m_axis.tlast   = r_m_tlast;
    assign frame_drop     = r_frame_drop;
    assign frames_pending = w_count;

`ifdef FIFO_TX_STATS_EN
    logic [31:0] r_tx_frame_cnt;
    logic [31:0] r_drop_cnt;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_tx_frame_cnt <= '0;
            r_drop_cnt     <= '0;
        end else begin
            if (w_pop) begin
                r_tx_frame_cnt <= r_tx_frame_cnt + 32'd1;
            end
            if (r_frame_drop) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
            end
        end
    end

    assign tx_frame_cnt = r_tx_frame_cnt;
    assign drop_cnt     = r_drop_cnt;
`endif

endmodule

// File: tb/tb_fifo_tx.sv
// Self-checking bench for fifo_tx: vector table, multi-cycle corner sequences and a
// randomized run scored against an in-order frame queue model.
module tb_fifo_tx;

    localparam int unsigned DEPTH = eth_fifo_pkg::FIFO_TX_DEPTH;
    localparam int unsigned MAXF  = eth_fifo_pkg::FIFO_TX_MAX_FRAMES;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       frame_drop;
    logic [3:0] frames_pending;
`ifdef FIFO_TX_STATS_EN
    logic [31:0] tx_frame_cnt;
    logic [31:0] drop_cnt;
`endif

    fifo_tx_if s_if ();
    fifo_tx_if m_if ();

    fifo_tx #(.DEPTH(DEPTH), .MAX_FRAMES(MAXF)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axis         (s_if),
        .m_axis         (m_if),
        .frame_drop     (frame_drop),
        .frames_pending (frames_pending)
`ifdef FIFO_TX_STATS_EN
        ,
        .tx_frame_cnt   (tx_frame_cnt),
        .drop_cnt       (drop_cnt)
`endif
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        int unsigned len;
        logic [3:0]  lkeep;
        int          mode;
        int unsigned exp_beats;
        int unsigned exp_drops;
    } vec_t;

    beat_t       exp_q[$];
    beat_t       rx_q[$];
    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned cyc = 0;
    int unsigned drop_seen = 0;
    int unsigned commits = 0;
    int unsigned last_commit_cyc = 0;
    int unsigned last_rise_cyc = 0;
    int unsigned stall_err = 0;
    int unsigned bubble_err = 0;
    int          m_mode = 1;   // 0 ready low, 1 ready high, 2 toggle, 3 random
    bit          nine_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            case (m_mode)
                0:       m_if.tready = 1'b0;
                1:       m_if.tready = 1'b1;
                2:       m_if.tready = ~m_if.tready;
                default: m_if.tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: collects accepted beats and flags stall instability / bubbles.
    initial begin
        logic  prev_stall;
        logic  prev_valid;
        logic  in_frame;
        beat_t prev_beat;
        beat_t cur;
        prev_stall = 0; prev_valid = 0; in_frame = 0; prev_beat = '0;
        forever begin
            @(negedge aclk);
            cur = {m_if.tdata, m_if.tkeep, m_if.tlast};
            if (!aresetn) begin
                prev_stall = 0; prev_valid = 0; in_frame = 0;
            end else begin
                if (prev_stall && (!m_if.tvalid || cur != prev_beat)) stall_err++;
                if (in_frame && !m_if.tvalid) bubble_err++;
                if (m_if.tvalid && !prev_valid) last_rise_cyc = cyc;
                if (m_if.tvalid && m_if.tready) begin
                    rx_q.push_back(cur);
                    in_frame = !m_if.tlast;
                end
                if (frame_drop) drop_seen++;
                prev_stall = m_if.tvalid && !m_if.tready;
                prev_valid = m_if.tvalid;
                prev_beat  = cur;
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int unsigned waitc;
        logic        hs;
        waitc = 0; hs = 0;
        s_if.tdata = d; s_if.tkeep = k; s_if.tlast = l; s_if.tvalid = 1'b1;
        while (!hs && waitc < 3000) begin
            @(negedge aclk);
            hs = s_if.tready;
            @(posedge aclk);
            #1;
            waitc++;
        end
        s_if.tvalid = 1'b0;
        if (!hs) begin
            n_total++;
            $display("FAIL s_handshake: no tready after %0d cycles, required a handshake", waitc);
        end else if (l) begin
            commits++;
            last_commit_cyc = cyc;
        end
    endtask

    task automatic send_frame(input int unsigned len, input logic [3:0] lkeep,
                              input bit gaps, input bit deliver);
        logic [31:0] d;
        logic [3:0]  kin;
        logic        l;
        int unsigned g;
        for (int unsigned i = 0; i < len; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) begin @(posedge aclk); #1; end
            end
            d   = $urandom;
            l   = (i == len - 1);
            kin = l ? lkeep : 4'($urandom);
            if (deliver) exp_q.push_back({d, l ? lkeep : 4'hF, l});
            send_beat(d, kin, l);
        end
    endtask

    task automatic wait_drain(input string name, input int unsigned budget);
        int unsigned c;
        c = 0;
        while ((rx_q.size() < exp_q.size() || frames_pending != 0 || m_if.tvalid) && c < budget) begin
            @(posedge aclk);
            #1;
            c++;
        end
        repeat (8) @(posedge aclk);
        #1;
        if (c >= budget) begin
            n_total++;
            $display("FAIL %s_drain: %0d of %0d beats after %0d cycles", name, rx_q.size(), exp_q.size(), c);
        end
    endtask

    task automatic compare_rx(input string name, input int unsigned exp_count);
        int unsigned bad;
        bad = 0;
        check({name, "_beats"}, 64'(rx_q.size()), 64'(exp_count));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            if (rx_q[i] !== exp_q[i]) begin
                if (bad == 0) $display("  %s first differing beat %0d: got %h want %h", name, i, rx_q[i], exp_q[i]);
                bad++;
            end
        end
        check({name, "_content"}, 64'(bad), 64'd0);
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

    initial begin
        vec_t        vt[8];
        int unsigned drop0;
        int unsigned commit0;
        int unsigned c;
        int unsigned frames_since_rst;
        string       nm;

        s_if.tvalid = 0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_s_tready", s_if.tready, 0);
        check("rst_m_tvalid", m_if.tvalid, 0);
        check("rst_m_tlast", m_if.tlast, 0);
        check("rst_frame_drop", frame_drop, 0);
        check("rst_pending", frames_pending, 0);
        aresetn = 1;
        @(posedge aclk);
        #1;
        check("post_rst_s_tready", s_if.tready, 1);

        vt[0] = '{16,   4'hF, 1, 16,   0};
        vt[1] = '{5,    4'h3, 1, 5,    0};
        vt[2] = '{1,    4'h1, 1, 1,    0};
        vt[3] = '{20,   4'h7, 2, 20,   0};
        vt[4] = '{1100, 4'hF, 1, 0,    1};
        vt[5] = '{10,   4'hF, 1, 10,   0};
        vt[6] = '{1024, 4'h8, 3, 1024, 0};
        vt[7] = '{1025, 4'hF, 1, 0,    1};

        for (int t = 0; t < 8; t++) begin
            nm = $sformatf("vec%0d", t);
            m_mode = vt[t].mode;
            drop0 = drop_seen; stall_err = 0; bubble_err = 0; last_rise_cyc = 0;
            send_frame(vt[t].len, vt[t].lkeep, 0, vt[t].exp_beats != 0);
            wait_drain(nm, 4000);
            compare_rx(nm, vt[t].exp_beats);
            if (vt[t].exp_beats != 0)
                check({nm, "_latency"}, 64'(last_rise_cyc - last_commit_cyc), 64'd2);
            check({nm, "_drops"}, 64'(drop_seen - drop0), 64'(vt[t].exp_drops));
            check({nm, "_pending"}, frames_pending, 0);
            check({nm, "_stall"}, 64'(stall_err), 0);
            check({nm, "_bubble"}, 64'(bubble_err), 0);
        end

        // Nine 4-word frames against a stalled sink: only eight fit in the ring.
        m_mode = 0;
        @(posedge aclk);
        #1;
        commit0 = commits; stall_err = 0; bubble_err = 0;
        fork
            begin
                for (int f = 0; f < 9; f++) send_frame(4, 4'($urandom_range(1, 15)), 0, 1);
                nine_done = 1;
            end
        join_none
        repeat (120) @(posedge aclk);
        #1;
        check("nine_commits", 64'(commits - commit0), 64'd8);
        check("nine_pending", frames_pending, 8);
        check("nine_s_tready", s_if.tready, 0);
        m_mode = 1;
        c = 0;
        while (!nine_done && c < 2000) begin @(posedge aclk); #1; c++; end
        wait_drain("nine", 2000);
        compare_rx("nine", 36);
        check("nine_stall", 64'(stall_err), 0);

        // Reset in the middle of a frame while an earlier frame waits at the output.
        m_mode = 0;
        drop0 = drop_seen;
        send_frame(3, 4'hF, 0, 0);
        repeat (4) @(posedge aclk);
        #1;
        check("mid_rst_pre_tvalid", m_if.tvalid, 1);
        check("mid_rst_pre_pending", frames_pending, 1);
        for (int w = 0; w < 4; w++) send_beat($urandom, 4'hF, 0);
        s_if.tdata = $urandom; s_if.tvalid = 1;
        aresetn = 0;
        @(posedge aclk);
        #1;
        check("mid_rst_m_tvalid", m_if.tvalid, 0);
        check("mid_rst_m_tlast", m_if.tlast, 0);
        check("mid_rst_s_tready", s_if.tready, 0);
        check("mid_rst_pending", frames_pending, 0);
        check("mid_rst_frame_drop", frame_drop, 0);
        s_if.tvalid = 0;
        @(posedge aclk);
        #1;
        aresetn = 1;
        exp_q.delete(); rx_q.delete();
        m_mode = 1;
        frames_since_rst = 0;
        @(posedge aclk);
        #1;
        send_frame(10, 4'h1, 0, 1);
        frames_since_rst++;
        wait_drain("post_rst", 500);
        compare_rx("post_rst", 10);
        check("mid_rst_no_drop", 64'(drop_seen - drop0), 0);

        // Randomized traffic: random lengths, keeps, source gaps and sink backpressure.
        m_mode = 3;
        stall_err = 0; bubble_err = 0; drop0 = drop_seen;
        fork
            begin
                for (int f = 0; f < 25; f++)
                    send_frame($urandom_range(1, 64), 4'($urandom_range(1, 15)), 1, 1);
            end
        join
        frames_since_rst += 25;
        wait_drain("rand", 20000);
        compare_rx("rand", 64'(exp_q.size()) == 0 ? 0 : exp_q.size());
        check("rand_drops", 64'(drop_seen - drop0), 0);
        check("rand_pending", frames_pending, 0);
        check("rand_stall", 64'(stall_err), 0);
        check("rand_bubble", 64'(bubble_err), 0);

`ifdef FIFO_TX_STATS_EN
        check("stats_tx_frames", tx_frame_cnt, 64'(frames_since_rst));
        check("stats_drops", drop_cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
